// File: rtl/mem_copy_engine.sv
// mem_copy_engine
//   Block-copy initiator for a simple dual-port RAM (port 1 read, port 2
//   write, shared clock). On start it copies `length` consecutive words from
//   src_addr to dst_addr. The direction is chosen so that overlapping regions
//   copy correctly, and completion is reported with a one-cycle done pulse.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   start                    launch a copy (sampled only while idle)
//   src_addr, dst_addr       first source / destination word address
//   length                   word count, 0 .. 2^ADDR_WIDTH
//   busy, done               copy in progress / one-cycle completion pulse
//   port1_addr               RAM read address
//   port1_data_out           RAM read data (one cycle after port1_addr)
//   port1_data_in            unused write data on the read port (tied 0)
//   port1_write_en           unused write strobe on the read port (tied 0)
//   port2_addr               RAM write address
//   port2_data_in            RAM write data
//   port2_write_en           RAM write strobe
module mem_copy_engine #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] port1_addr,
  input  logic [DATA_WIDTH-1:0] port1_data_out,
  output logic [DATA_WIDTH-1:0] port1_data_in,
  output logic                  port1_write_en,
  output logic [ADDR_WIDTH-1:0] port2_addr,
  output logic [DATA_WIDTH-1:0] port2_data_in,
  output logic                  port2_write_en
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [ADDR_WIDTH-1:0] rd_addr_p0;
  logic [ADDR_WIDTH-1:0] wr_addr_p0;
  logic [ADDR_WIDTH:0]   rd_left_p0;
  logic                  rd_act_p0;
  logic                  desc_p0;
  logic [ADDR_WIDTH-1:0] wr_addr_p1;
  logic                  vld_p1;

  logic [ADDR_WIDTH-1:0] delta;
  logic [ADDR_WIDTH-1:0] len_m1;
  logic                  desc_start;
  logic                  launch;
  logic                  advance;

  // Step one word in the chosen direction; wraps modulo the RAM depth.
  function automatic logic [ADDR_WIDTH-1:0] step_addr(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic                  down
  );
    return down ? addr - 1'b1 : addr + 1'b1;
  endfunction

  // A non-zero forward distance shorter than the block means the destination
  // overlaps the tail of the source, so copy from the top down. For a full
  // 2^ADDR_WIDTH block the low bits of length are zero and len_m1 wraps to
  // the last index, which is what the descending start address needs.
  assign delta      = dst_addr - src_addr;
  assign len_m1     = length[ADDR_WIDTH-1:0] - 1'b1;
  assign desc_start = (delta != '0) && ({1'b0, delta} < length);
  assign launch     = (state == IDLE) && start && (length != '0);
  assign advance    = (state == RUN) && rd_act_p0 && (rd_left_p0 != '0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // RUN lasts length+1 cycles: length reads, and the final cycle only
  // carries the last write out of the pipeline.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = (length == '0) ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (!rd_act_p0) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Stage p0: read address issue
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr_p0 <= '0;
      rd_act_p0  <= 1'b0;
    end else if (launch) begin
      rd_addr_p0 <= desc_start ? src_addr + len_m1 : src_addr;
      rd_act_p0  <= 1'b1;
    end else if (advance) begin
      rd_addr_p0 <= step_addr(rd_addr_p0, desc_p0);
    end else if (state == RUN) begin
      rd_act_p0  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (launch) begin
      wr_addr_p0 <= desc_start ? dst_addr + len_m1 : dst_addr;
      rd_left_p0 <= length - 1'b1;
      desc_p0    <= desc_start;
    end else if (advance) begin
      wr_addr_p0 <= step_addr(wr_addr_p0, desc_p0);
      rd_left_p0 <= rd_left_p0 - 1'b1;
    end
  end

  // Stage p1: write address paired with the data returned by the RAM
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr_p1 <= '0;
      vld_p1     <= 1'b0;
    end else if ((state == RUN) && rd_act_p0) begin
      wr_addr_p1 <= wr_addr_p0;
      vld_p1     <= 1'b1;
    end else begin
      vld_p1     <= 1'b0;
    end
  end

  assign port1_addr     = rd_addr_p0;
  assign port1_data_in  = '0;
  assign port1_write_en = 1'b0;
  assign port2_addr     = wr_addr_p1;
  assign port2_write_en = vld_p1;
  // Gated so the write-data bus reads 0 whenever no write is issued.
  assign port2_data_in  = vld_p1 ? port1_data_out : '0;

endmodule

// File: tb/tb_mem_copy_engine.sv
module tb_mem_copy_engine;
  localparam int AW    = 6;
  localparam int DW    = 14;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;
  logic [AW:0]   length;
  logic          busy;
  logic          done;
  logic [AW-1:0] port1_addr;
  logic [DW-1:0] port1_data_out;
  logic [DW-1:0] port1_data_in;
  logic          port1_write_en;
  logic [AW-1:0] port2_addr;
  logic [DW-1:0] port2_data_in;
  logic          port2_write_en;

  mem_copy_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .busy(busy), .done(done),
    .port1_addr(port1_addr), .port1_data_out(port1_data_out),
    .port1_data_in(port1_data_in), .port1_write_en(port1_write_en),
    .port2_addr(port2_addr), .port2_data_in(port2_data_in),
    .port2_write_en(port2_write_en)
  );

  always #5 clk = ~clk;

  // Simple dual-port RAM with a bench-side preload port.
  logic [DW-1:0] mem [DEPTH];
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (port2_write_en) mem[port2_addr] <= port2_data_in;
    port1_data_out <= mem[port1_addr];
  end

  int checks = 0;
  int errors = 0;
  logic [AW-1:0] wr_log[$];
  int done_cnt = 0;

  always @(negedge clk) begin
    if (port2_write_en) wr_log.push_back(port2_addr);
    if (done) done_cnt++;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  logic [DW-1:0] pre [DEPTH];

  task automatic load_mem();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      ld_en   = 1'b1;
      ld_addr = AW'(i);
      ld_data = pre[i];
    end
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_p2we"}, int'(port2_write_en), 0);
    check({tag, "_p1addr"}, int'(port1_addr), 0);
    check({tag, "_p2addr"}, int'(port2_addr), 0);
    check({tag, "_p2din"}, int'(port2_data_in), 0);
  endtask

  // Runs one copy and checks it against a memmove-style model: the final
  // memory equals the old image with dst[i] = old src[i], plus write order,
  // write count and completion latency derived from the direction rule.
  task automatic do_copy(input int s, input int d, input int l, input bit poke,
                         output int lat, output int first_wr);
    logic [DW-1:0] old  [DEPTH];
    logic [DW-1:0] expm [DEPTH];
    int delta;
    bit descd;
    int mism;
    int bad;
    int exp_addr;
    for (int i = 0; i < DEPTH; i++) begin
      old[i]  = mem[i];
      expm[i] = mem[i];
    end
    for (int i = 0; i < l; i++) expm[(d + i) % DEPTH] = old[(s + i) % DEPTH];
    delta = (d - s + DEPTH) % DEPTH;
    descd = (delta != 0) && (delta < l);

    @(negedge clk);
    wr_log.delete();
    start    = 1'b1;
    src_addr = AW'(s);
    dst_addr = AW'(d);
    length   = (AW+1)'(l);
    @(negedge clk);
    start    = 1'b0;
    src_addr = AW'($urandom);
    dst_addr = AW'($urandom);
    length   = (AW+1)'($urandom_range(0, DEPTH));
    lat = 1;
    check("busy_first", int'(busy), (l != 0) ? 1 : 0);
    while (!done && lat < 200) begin
      start = poke && (lat == 3);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check("done_seen", int'(done), 1);
    check("busy_at_done", int'(busy), 0);
    @(negedge clk);
    check("done_pulse", int'(done), 0);
    check("latency", lat, (l == 0) ? 1 : l + 2);
    check("wr_count", wr_log.size(), l);
    first_wr = (wr_log.size() > 0) ? int'(wr_log[0]) : -1;
    bad = 0;
    for (int k = 0; k < wr_log.size() && k < l; k++) begin
      exp_addr = descd ? (d + l - 1 - k) % DEPTH : (d + k) % DEPTH;
      if (int'(wr_log[k]) != exp_addr) bad++;
    end
    check("wr_order", bad, 0);
    mism = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== expm[i]) mism++;
    check("mem_image", mism, 0);
  endtask

  typedef struct {
    int s;
    int d;
    int l;
    int lat;
    int first;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int lat, fw, dc, mism, delta, maxl, s, d, l;

    tbl[0] = '{s: 0,  d: 32, l: 8,  lat: 10, first: 32};
    tbl[1] = '{s: 4,  d: 6,  l: 5,  lat: 7,  first: 10};
    tbl[2] = '{s: 6,  d: 4,  l: 5,  lat: 7,  first: 4};
    tbl[3] = '{s: 60, d: 2,  l: 8,  lat: 10, first: 9};
    tbl[4] = '{s: 0,  d: 0,  l: 64, lat: 66, first: 0};
    tbl[5] = '{s: 5,  d: 5,  l: 0,  lat: 1,  first: -1};
    tbl[6] = '{s: 10, d: 10, l: 3,  lat: 5,  first: 10};
    tbl[7] = '{s: 63, d: 0,  l: 2,  lat: 4,  first: 1};

    rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    check("reset_p1we", int'(port1_write_en), 0);
    check("reset_p1din", int'(port1_data_in), 0);
    rst = 1'b0;

    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < DEPTH; i++) pre[i] = DW'(i + 100);
      load_mem();
      do_copy(tbl[t].s, tbl[t].d, tbl[t].l, 1'b0, lat, fw);
      check($sformatf("tbl%0d_latency", t), lat, tbl[t].lat);
      check($sformatf("tbl%0d_first_wr", t), fw, tbl[t].first);
    end

    // start pulsed mid-copy with garbage inputs must be ignored
    for (int i = 0; i < DEPTH; i++) pre[i] = DW'(i + 100);
    load_mem();
    do_copy(0, 32, 8, 1'b1, lat, fw);
    check("busy_start_latency", lat, 10);
    check("busy_start_first_wr", fw, 32);

    // reset taking effect at the start of the third write cycle
    for (int i = 0; i < DEPTH; i++) pre[i] = DW'(i + 100);
    load_mem();
    @(negedge clk);
    wr_log.delete();
    start = 1'b1; src_addr = 6'd0; dst_addr = 6'd32; length = 7'd8;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    dc  = done_cnt;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("midrst_no_done", done_cnt, dc);
    check("midrst_busy", int'(busy), 0);
    check("midrst_wr_count", wr_log.size(), 2);
    mism = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 32 || i == 33) begin
        if (mem[i] !== DW'(i - 32 + 100)) mism++;
      end else if (mem[i] !== pre[i]) mism++;
    end
    check("midrst_mem", mism, 0);
    do_copy(8, 40, 6, 1'b0, lat, fw);
    check("after_rst_first_wr", fw, 40);

    // randomized copies, avoiding lengths that overlap both ends of a
    // wrapped region (no direction can copy those correctly)
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < DEPTH; i++) pre[i] = DW'($urandom);
      load_mem();
      s = int'($urandom_range(0, DEPTH - 1));
      d = int'($urandom_range(0, DEPTH - 1));
      delta = (d - s + DEPTH) % DEPTH;
      maxl = (delta == 0) ? DEPTH : ((delta > DEPTH - delta) ? delta : DEPTH - delta);
      l = int'($urandom_range(0, maxl));
      do_copy(s, d, l, r[0], lat, fw);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
